mod_inv: RTL
============

// Module: mod_inv
// PURPOSE
//  Modular inverse over Z_q: out = a^(PRIME-2) mod PRIME (Fermat), undoing a mult_mod scaling (e.g. n^-1 / Montgomery factors in INTT).
//  Left-to-right square-and-multiply FSM; one pipelined modular multiplier reused every step; valid/ready on both sides.
// PARAMETERS
//  WIDTH    12    coefficient width (`WIDTH)
//  PRIME    3329  modulus q (`PRIME); requires 2*PRIME > 2^WIDTH
//  MUL_LAT  2     multiplier latency, operands-in to product-out, cycles
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      async active-low reset
//  in_valid   in   1      operand a valid
//  in_ready   out  1      block can accept operand
//  in_a       in   WIDTH  operand a, 0..2^WIDTH-1
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_inv    out  WIDTH  a^-1 mod PRIME, range 0..PRIME-1
//  out_err    out  1      1 = a=0 mod PRIME (no inverse; out_inv=0)
// BEHAVIOUR
//  - One clock domain. Async active-low reset; all state clears immediately.
//  - Reset values: state=IDLE, in_ready=1, out_valid=0, out_inv=0, out_err=0.
//  - Exponent E=PRIME-2 (3327=12'b1100_1111_1111), EBITS=12, POP=10, fixed at elaboration.
//  - States: IDLE, SQR, MUL, DONE.
//  - IDLE: in_ready=1. On in_valid&&in_ready (cycle 0):
//    a_r = (in_a>=PRIME) ? in_a-PRIME : in_a; r = a_r; bit index i = EBITS-2; -> SQR.
//  - SQR: issue r*r; after MUL_LAT cycles capture r.
//    If E[i]: -> MUL. Else if i==0: -> DONE. Else: i--, stay SQR.
//  - MUL: issue r*a_r; after MUL_LAT cycles capture r.
//    i==0 -> DONE, else i--, -> SQR.
//  - Each op costs MUL_LAT+1 cycles (issue, wait, capture).
//    Cycle counter, not a multiplier valid, marks capture; stale pipeline data is never used.
//  - Op count: (EBITS-1) squares + (POP-1) multiplies = 20.
//    out_valid rises at cycle 1+20*(MUL_LAT+1) = 61 (default params), independent of a.
//  - DONE: out_valid=1, out_inv=r, out_err=(a_r==0); held stable until out_ready.
//    in_ready=0 in SQR, MUL and DONE.
//  - out_valid&&out_ready -> IDLE next cycle. No new operand accepted in the handshake cycle
//    (throughput 1 per 62 cycles). out_inv/out_err keep their last value after the handshake.
//  - a_r=0 runs the full sequence (constant timing, no data-dependent shortcut); result 0, out_err=1.
//  - Products are fully reduced to [0,PRIME-1] by the multiplier. r, a_r are always < PRIME.
//  - in_valid outside IDLE is ignored; in_a is sampled only in the accept cycle.
//  - rst_n low mid-operation: abort, back to IDLE, outputs at reset values; no residual out_valid.
// STRUCTURE
//  - Shared package kyber_pkg: WIDTH, PRIME, INV_EXP=PRIME-2, INV_EBITS=$clog2(INV_EXP+1),
//    INV_POP (popcount), state enum inv_state_t {IDLE,SQR,MUL,DONE}.
//  - One sub-module: mult_mod (existing Barrett multiplier), one instance.
//    Operand mux selects (r,r) in SQR and (r,a_r) in MUL.
//  - Local: FSM, bit index i, latency counter 0..MUL_LAT, r/a_r registers.
// TESTING
//  - a=1 -> out_inv=1, out_err=0, out_valid exactly 61 cycles after the accept cycle.
//  - a=2 -> 1665; a=17 -> 1175; a=3328 -> 3328.
//  - a=0 -> out_inv=0, out_err=1, still 61 cycles; a=3330 (>=PRIME) -> reduced to 1 -> out_inv=1.
//  - out_ready held low 5 cycles after out_valid -> out_valid, out_inv stable, in_ready=0;
//    release -> IDLE; next operand accepted one cycle later.
//  - in_valid toggled with new in_a during SQR/MUL -> ignored, result matches the accepted operand.
//  - rst_n pulsed low at cycle 30 of an op -> out_valid=0 at once, in_ready=1 after release,
//    next op (a=17) -> 1175.
//  - Random sweep a in 1..3328 with random out_ready -> (a*out_inv) mod 3329 == 1 for all a.

Source files
------------

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants, inverse exponent and FSM state type
package kyber_pkg;

    localparam int WIDTH   = 12;
    localparam int PRIME   = 3329;
    localparam int MUL_LAT = 2;

    function automatic int popcount(input int v);
        int c;
        c = 0;
        for (int b = 0; b < 32; b++) begin
            c += int'(v[b]);
        end
        return c;
    endfunction

    // Fermat exponent: a^(q-2) == a^-1 mod q
    localparam int INV_EXP   = PRIME - 2;
    localparam int INV_EBITS = $clog2(INV_EXP + 1);
    localparam int INV_POP   = popcount(INV_EXP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } inv_state_t;

endpackage

// File: rtl/mult_mod.sv
// rtl/mult_mod.sv - pipelined Barrett modular multiplier, prod = a*b mod PRIME
// Ports: clk, rst_n (async active-low), a/b operands (< PRIME),
//        prod fully reduced product, valid MUL_LAT cycles after a/b.
module mult_mod #(
    parameter int WIDTH   = 12,
    parameter int PRIME   = 3329,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod
);

    localparam int K = 2 * WIDTH;
    localparam longint unsigned MU_L = (64'd1 << K) / 64'(PRIME);
    localparam logic [WIDTH:0]   MU   = (WIDTH+1)'(MU_L);
    localparam logic [WIDTH:0]   Q_T  = (WIDTH+1)'(PRIME);
    localparam logic [WIDTH+1:0] Q_R  = (WIDTH+2)'(PRIME);

    logic [K-1:0]       p_q;
    logic [3*WIDTH:0]   pm;
    logic [WIDTH:0]     t;
    logic [K+WIDTH:0]   tq;
    logic [K-1:0]       rem;
    logic [WIDTH+1:0]   r0, r1, r2;
    logic [WIDTH-1:0]   red;
    logic               unused_bits;

    // stage 1: raw product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        end
    end

    // Barrett estimate undershoots the true quotient by at most 2,
    // so two conditional subtractions give a fully reduced result.
    always_comb begin
        pm  = {{(WIDTH+1){1'b0}}, p_q} * {{K{1'b0}}, MU};
        t   = pm[3*WIDTH:K];
        tq  = {{K{1'b0}}, t} * {{K{1'b0}}, Q_T};
        rem = p_q - tq[K-1:0];
        r0  = rem[WIDTH+1:0];
        r1  = (r0 >= Q_R) ? r0 - Q_R : r0;
        r2  = (r1 >= Q_R) ? r1 - Q_R : r1;
        red = r2[WIDTH-1:0];
    end

    assign unused_bits = ^{pm[K-1:0], tq[K+WIDTH:K], rem[K-1:WIDTH+2], r2[WIDTH+1:WIDTH]};

    generate
        if (MUL_LAT == 1) begin : g_lat1
            assign prod = red;
        end else begin : g_latn
            logic [WIDTH-1:0] dly [MUL_LAT-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < MUL_LAT-1; k++) dly[k] <= '0;
                end else begin
                    dly[0] <= red;
                    for (int k = 1; k < MUL_LAT-1; k++) dly[k] <= dly[k-1];
                end
            end
            assign prod = dly[MUL_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/mod_inv.sv
// rtl/mod_inv.sv - modular inverse a^(PRIME-2) mod PRIME by square-and-multiply
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a operand side;
//        out_valid/out_ready/out_inv/out_err result side (out_err=1 when a==0 mod PRIME).
module mod_inv #(
    parameter int WIDTH   = kyber_pkg::WIDTH,
    parameter int PRIME   = kyber_pkg::PRIME,
    parameter int MUL_LAT = kyber_pkg::MUL_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_inv,
    output logic             out_err
);
    import kyber_pkg::*;

    localparam int EXP   = PRIME - 2;
    localparam int EBITS = $clog2(EXP + 1);
    localparam int IBITS = $clog2(EBITS);
    localparam int CBITS = $clog2(MUL_LAT + 1);
    localparam logic [EBITS-1:0] E     = EBITS'(EXP);
    localparam logic [WIDTH:0]   Q_EXT = (WIDTH+1)'(PRIME);

    inv_state_t       state, state_d;
    logic [WIDTH-1:0] r, a_r, prod, op_b, a_red;
    logic [WIDTH:0]   a_ext;
    logic [IBITS-1:0] i;
    logic [CBITS-1:0] cnt;
    logic             cap;

    // in_a < 2^WIDTH < 2*PRIME, so one subtraction reduces it
    assign a_ext = {1'b0, in_a};
    assign a_red = (a_ext >= Q_EXT) ? WIDTH'(a_ext - Q_EXT) : in_a;

    assign op_b = (state == MUL) ? a_r : r;

    mult_mod #(.WIDTH(WIDTH), .PRIME(PRIME), .MUL_LAT(MUL_LAT)) u_mult_mod (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (r),
        .b     (op_b),
        .prod  (prod)
    );

    // r is held constant for the whole op, so the product present at
    // cnt==MUL_LAT belongs to this op regardless of what the pipe held before.
    assign cap = ((state == SQR) || (state == MUL)) && (cnt == CBITS'(MUL_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SQR;
            end
            SQR: begin
                if (cap) begin
                    if (E[i])        state_d = MUL;
                    else if (i == 0) state_d = DONE;
                end
            end
            MUL: begin
                if (cap) state_d = (i == 0) ? DONE : SQR;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= '0;
            a_r     <= '0;
            i       <= '0;
            cnt     <= '0;
            out_inv <= '0;
            out_err <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_r <= a_red;
                r   <= a_red;
                i   <= IBITS'(EBITS - 2);
                cnt <= '0;
            end else if (state == SQR || state == MUL) begin
                if (cap) begin
                    r   <= prod;
                    cnt <= '0;
                    if (state_d == DONE) begin
                        out_inv <= prod;
                        out_err <= (a_r == '0);
                    end
                    // a square followed by a multiply keeps the same bit index
                    if (state == SQR && !E[i] && i != 0) i <= i - 1'b1;
                    if (state == MUL && i != 0)          i <= i - 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
